// File: rtl/upower_fetch_issue_if.sv
// Fetch/issue bus bundle: instruction-memory handshake, decode handshake and branch outcome.
// The master modport is the sequencer side; the slave modport is the memory/decode/execute side.
interface upower_fetch_issue_if #(
  parameter int ADDR_W = 32
) ();
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              dec_valid;
  logic              dec_ready;
  logic [5:0]        opcode;
  logic [9:0]        ext_opcode;
  logic [4:0]        rt;
  logic [4:0]        ra;
  logic [4:0]        rb;
  logic [15:0]       imm16;
  logic [ADDR_W-1:0] pc_out;
  logic              br_valid;
  logic              beq;
  logic              bne;
  logic              zero;
  logic              redirect;

  modport master (
    output imem_req, imem_addr, dec_valid, opcode, ext_opcode, rt, ra, rb, imm16,
           pc_out, redirect,
    input  imem_ack, imem_rdata, dec_ready, br_valid, beq, bne, zero
  );

  modport slave (
    input  imem_req, imem_addr, dec_valid, opcode, ext_opcode, rt, ra, rb, imm16,
           pc_out, redirect,
    output imem_ack, imem_rdata, dec_ready, br_valid, beq, bne, zero
  );
endinterface

// File: rtl/upower_fetch_issue.sv
// uPOWER fetch/issue sequencer: fetch one word, issue its fields to decode, and
// stall on a conditional branch until the outcome arrives, then update the PC.
module upower_fetch_issue #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [5:0]        BRANCH_OPC = 6'd16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  upower_fetch_issue_if.master  bus
);
  localparam logic [1:0] ST_FETCH   = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_ISSUE   = 2'd2;
  localparam logic [1:0] ST_RESOLVE = 2'd3;

  logic [1:0]        state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_out_reg;
  logic [31:0]       ir_reg;
  logic              imem_req_reg;
  logic              dec_valid_reg;
  logic              redirect_reg;
  logic              taken;
  logic [ADDR_W-1:0] br_offset;

  // Both beq and bne asserted makes the branch taken whatever zero says.
  assign taken     = (bus.beq & bus.zero) | (bus.bne & ~bus.zero);
  assign br_offset = {{(ADDR_W-16){ir_reg[15]}}, ir_reg[15:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_FETCH;
      pc_reg        <= RESET_PC;
      pc_out_reg    <= '0;
      ir_reg        <= '0;
      imem_req_reg  <= 1'b0;
      dec_valid_reg <= 1'b0;
      redirect_reg  <= 1'b0;
    end else begin
      redirect_reg <= 1'b0;
      case (state_reg)
        ST_FETCH: begin
          imem_req_reg <= 1'b1;
          state_reg    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.imem_ack) begin
            ir_reg        <= bus.imem_rdata;
            pc_out_reg    <= pc_reg;
            imem_req_reg  <= 1'b0;
            dec_valid_reg <= 1'b1;
            state_reg     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus.dec_ready) begin
            dec_valid_reg <= 1'b0;
            if (ir_reg[31:26] == BRANCH_OPC) begin
              state_reg <= ST_RESOLVE;
            end else begin
              pc_reg    <= pc_reg + ADDR_W'(4);
              state_reg <= ST_FETCH;
            end
          end
        end
        ST_RESOLVE: begin
          if (bus.br_valid) begin
            pc_reg       <= taken ? (pc_out_reg + br_offset) : (pc_out_reg + ADDR_W'(4));
            redirect_reg <= taken;
            state_reg    <= ST_FETCH;
          end
        end
        default: state_reg <= ST_FETCH;
      endcase
    end
  end

  assign bus.imem_req   = imem_req_reg;
  assign bus.imem_addr  = pc_reg;
  assign bus.dec_valid  = dec_valid_reg;
  assign bus.pc_out     = pc_out_reg;
  assign bus.redirect   = redirect_reg;
  assign bus.opcode     = ir_reg[31:26];
  assign bus.ext_opcode = ir_reg[10:1];
  assign bus.rt         = ir_reg[25:21];
  assign bus.ra         = ir_reg[20:16];
  assign bus.rb         = ir_reg[15:11];
  assign bus.imm16      = ir_reg[15:0];
endmodule
